multicycle_ctl: RTL and testbench
=================================

// Module: multicycle_ctl
// PURPOSE
//  Moore/Mealy control FSM that sequences the shared multicycle MIPS datapath: PC, IR, one memory port, ALU, register file.
//  Decodes opcode[5:0] and drives ALUOp into the existing ALU control decoder (00 add, 01 sub, 10 use funct).
//  Stalls on a memory ready handshake; a watchdog flags a hung memory.
// PARAMETERS
//  TIMEOUT   255  max cycles waiting for mem_ready in one memory state; 0 disables the watchdog
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  async active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag (used in BRANCH)
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if zero
//  i_or_d       out  1  0 = memory address from PC, 1 = from ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR load
//  mem_to_reg   out  1  register write data: 1 = MDR, 0 = ALUOut
//  reg_dst      out  1  1 = rd, 0 = rt
//  reg_write    out  1  register file write
//  alu_src_a    out  1  0 = PC, 1 = reg A
//  alu_src_b    out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  2  to ALU control decoder
//  pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  illegal_op   out  1  one-cycle pulse on an unsupported opcode
//  mem_fault    out  1  sticky; cleared only by reset
//  state        out  4  current state code (debug)
// BEHAVIOUR
//  Reset: state=IDLE(0), watchdog=0, mem_fault=0. All outputs 0 while in IDLE.
//  Default for every output not listed in a state: 0.
//  States and outputs:
//   IDLE(0): -> FETCH unconditionally.
//   FETCH(1): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//     ir_write = pc_write = mem_ready (Mealy). -> DECODE when mem_ready.
//   DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00. Transition by opcode:
//     100011 lw / 101011 sw -> MEMADR; 000000 R -> EXEC; 000100 beq -> BRANCH;
//     000010 j -> JUMP; 001000 addi -> ADDIEX; otherwise -> ILLEGAL.
//   MEMADR(3): alu_src_a=1, alu_src_b=10, alu_op=00. -> MEMRD (lw) or MEMWR (sw).
//   MEMRD(4): mem_read, i_or_d=1. -> MEMWB when mem_ready.
//   MEMWB(5): reg_write, mem_to_reg=1, reg_dst=0. -> FETCH.
//   MEMWR(6): mem_write, i_or_d=1. -> FETCH when mem_ready.
//   EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10. -> RWB.
//   RWB(8): reg_write, reg_dst=1, mem_to_reg=0. -> FETCH.
//   BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. -> FETCH.
//   JUMP(10): pc_write, pc_source=10. -> FETCH.
//   ADDIEX(11): alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
//   ADDIWB(12): reg_write, reg_dst=0, mem_to_reg=0. -> FETCH.
//   ILLEGAL(13): illegal_op=1 for exactly this cycle; no writes. -> FETCH; PC already advanced.
//   FAULT(14): all outputs 0, mem_fault=1. Held until reset.
//  Handshake: in FETCH/MEMRD/MEMWR, request and address selects stay stable until mem_ready.
//   mem_ready is ignored in every other state.
//  Latency with mem_ready=1 on the first cycle: R/addi/sw 4 cycles, lw 5, beq/j 3.
//  Watchdog: counter clears on entry to each memory state and increments each waiting cycle.
//   If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_ready -> FAULT.
//   mem_ready in the same cycle the counter reaches TIMEOUT wins; normal transition, no fault.
//  Async reset in any state, including mid-wait, returns to IDLE on the next edge.
//   No partial write is committed after reset assertion.
// TESTING
//  add (op 000000), mem_ready=1 -> states 1,2,7,8,1; alu_op=10 in EXEC; reg_write,reg_dst=1 in RWB.
//  lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1,i_or_d=1; then MEMWB with mem_to_reg=1.
//  beq with zero=1 -> BRANCH: pc_write_cond=1, pc_source=01, alu_op=01; back to FETCH next cycle.
//  opcode 111111 -> ILLEGAL for one cycle, illegal_op pulse, no reg_write/mem_write; then FETCH.
//  TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles; mem_fault=1 sticky until rst_n low.
//  rst_n low mid-MEMWR -> all outputs 0 immediately; IDLE then FETCH after release.

Source files
------------

// File: rtl/multicycle_ctl_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface multicycle_ctl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               mem_fault, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               mem_fault, state
    );
endinterface

// File: rtl/multicycle_ctl.sv
// Control FSM sequencing the shared multicycle MIPS datapath, with a memory-hang watchdog.
// Moore outputs are registered from the next state; FETCH's ir_write/pc_write follow mem_ready.
module multicycle_ctl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctl_if.master bus
);
    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAdr  = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StRwb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StAddiEx  = 4'd11,
        StAddiWb  = 4'd12,
        StIllegal = 4'd13,
        StFault   = 4'd14
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam bit              WdogEn   = (TIMEOUT != 0);
    localparam int unsigned     CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] WdogLast = CntW'(WdogEn ? TIMEOUT - 1 : 0);

    state_e          r_state;
    state_e          w_next;
    ctl_t            r_ctl;
    logic [CntW-1:0] r_wdog;
    logic            r_mem_fault;
    logic            w_mem_state;
    logic            w_fetch_ready;
    logic            w_unused_zero;

    function automatic ctl_t ctl_of(state_e s);
        ctl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: c.alu_src_b = 2'b11;
            StMemAdr, StAddiEx: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            StRwb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            StJump: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            StAddiWb:  c.reg_write  = 1'b1;
            StIllegal: c.illegal_op = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next      = r_state;
        w_mem_state = 1'b0;
        case (r_state)
            StIdle: w_next = StFetch;
            StFetch: begin
                w_mem_state = 1'b1;
                if (bus.mem_ready) w_next = StDecode;
            end
            StDecode: begin
                case (bus.opcode)
                    OpLw, OpSw: w_next = StMemAdr;
                    OpRtype:    w_next = StExec;
                    OpBeq:      w_next = StBranch;
                    OpJ:        w_next = StJump;
                    OpAddi:     w_next = StAddiEx;
                    default:    w_next = StIllegal;
                endcase
            end
            StMemAdr: w_next = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                w_mem_state = 1'b1;
                if (bus.mem_ready) w_next = StMemWb;
            end
            StMemWr: begin
                w_mem_state = 1'b1;
                if (bus.mem_ready) w_next = StFetch;
            end
            StExec:   w_next = StRwb;
            StAddiEx: w_next = StAddiWb;
            StMemWb, StRwb, StBranch, StJump, StAddiWb, StIllegal: w_next = StFetch;
            StFault:  w_next = StFault;
            default:  w_next = StIdle;
        endcase
        // A late mem_ready on the final allowed wait cycle still wins over the fault.
        if (WdogEn && w_mem_state && !bus.mem_ready && (r_wdog == WdogLast)) begin
            w_next = StFault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ctl       <= '0;
            r_wdog      <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_of(w_next);
            if (w_next == StFault) r_mem_fault <= 1'b1;
            if (WdogEn && w_mem_state && !bus.mem_ready) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign w_fetch_ready     = (r_state == StFetch) && bus.mem_ready;
    assign bus.pc_write      = r_ctl.pc_write | w_fetch_ready;
    assign bus.ir_write      = w_fetch_ready;
    assign bus.pc_write_cond = r_ctl.pc_write_cond;
    assign bus.i_or_d        = r_ctl.i_or_d;
    assign bus.mem_read      = r_ctl.mem_read;
    assign bus.mem_write     = r_ctl.mem_write;
    assign bus.mem_to_reg    = r_ctl.mem_to_reg;
    assign bus.reg_dst       = r_ctl.reg_dst;
    assign bus.reg_write     = r_ctl.reg_write;
    assign bus.alu_src_a     = r_ctl.alu_src_a;
    assign bus.alu_src_b     = r_ctl.alu_src_b;
    assign bus.alu_op        = r_ctl.alu_op;
    assign bus.pc_source     = r_ctl.pc_source;
    assign bus.illegal_op    = r_ctl.illegal_op;
    assign bus.mem_fault     = r_mem_fault;
    assign bus.state         = r_state;

    // zero gates pc_write_cond inside the datapath, not here.
    assign w_unused_zero = bus.zero;
endmodule

// File: tb/tb_multicycle_ctl.sv
// Bench for multicycle_ctl: directed instruction walks with literal expectations, then random
// traffic checked every cycle against a route-based instruction model.
module tb_multicycle_ctl;
    localparam int unsigned Tmo = 4;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpBad  = 6'b111111;

    logic clk = 1'b0;
    logic rst_n;

    multicycle_ctl_if bus ();

    multicycle_ctl #(.TIMEOUT(Tmo)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: current state code, consecutive wait cycles, and remaining post-decode states.
    int         m_state;
    int         m_wait;
    int         m_route[$];
    logic [5:0] p_op;
    logic       p_rdy;
    bit         rand_op;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h (model state %0d)", name, $time, got, want,
                     m_state);
        end
    endtask

    // Bit order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg reg_dst
    // reg_write alu_src_a | alu_src_b | alu_op | pc_source | illegal_op mem_fault
    function automatic logic [17:0] dut_word();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.mem_fault};
    endfunction

    function automatic logic [17:0] exp_word(input int s, input logic rdy);
        logic [17:0] w;
        case (s)
            1:  w = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
            2:  w = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
            3:  w = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
            4:  w = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
            5:  w = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
            6:  w = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
            7:  w = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
            8:  w = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
            9:  w = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
            10: w = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
            11: w = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
            12: w = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
            13: w = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;
            14: w = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;
            default: w = '0;
        endcase
        if (s == 1) begin
            w[17] = rdy;
            w[12] = rdy;
        end
        return w;
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] r;
        case ($urandom_range(0, 6))
            0: r = OpLw;
            1: r = OpSw;
            2: r = OpR;
            3: r = OpBeq;
            4: r = OpJ;
            5: r = OpAddi;
            default: r = 6'($urandom);
        endcase
        return r;
    endfunction

    // Advance the model across one rising edge using the inputs that were applied before it.
    task automatic m_advance();
        bit mem;
        mem = (m_state == 1) || (m_state == 4) || (m_state == 6);
        if (mem && !p_rdy) begin
            m_wait++;
            if (Tmo != 0 && m_wait >= int'(Tmo)) begin
                m_state = 14;
                m_wait  = 0;
            end
        end else begin
            m_wait = 0;
            case (m_state)
                0: m_state = 1;
                1: m_state = 2;
                2: begin
                    case (p_op)
                        OpLw:    m_route = '{3, 4, 5};
                        OpSw:    m_route = '{3, 6};
                        OpR:     m_route = '{7, 8};
                        OpBeq:   m_route = '{9};
                        OpJ:     m_route = '{10};
                        OpAddi:  m_route = '{11, 12};
                        default: m_route = '{13};
                    endcase
                    m_state = m_route.pop_front();
                end
                14: m_state = 14;
                default: m_state = (m_route.size() != 0) ? m_route.pop_front() : 1;
            endcase
        end
    endtask

    task automatic step(input logic [5:0] op, input logic z, input logic rdy);
        logic [5:0] use_op;
        @(negedge clk);
        m_advance();
        use_op = op;
        if (rand_op) use_op = (m_state <= 1) ? pick_op() : p_op;
        bus.opcode    = use_op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        p_op          = use_op;
        p_rdy         = rdy;
        #1;
        check("state", 32'(bus.state), m_state);
        check("ctl", 32'(dut_word()), 32'(exp_word(m_state, rdy)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(bus.state), 0);
        check("rst_outputs", 32'(dut_word()), 0);
        m_state = 0;
        m_wait  = 0;
        m_route.delete();
        @(negedge clk);
        check("rst_hold", 32'(bus.state), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rand_op       = 1'b0;
        bus.opcode    = OpR;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        p_op          = OpR;
        p_rdy         = 1'b0;
        m_state       = 0;
        m_wait        = 0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        do_reset();

        // R-type: 1,2,7,8 then back to FETCH
        step(OpR, 0, 1);
        check("add_fetch", 32'(bus.state), 1);
        check("add_ir_write", 32'(bus.ir_write), 1);
        step(OpR, 0, 1);
        check("add_decode", 32'(bus.state), 2);
        step(OpR, 0, 1);
        check("add_exec", 32'(bus.state), 7);
        check("add_exec_aluop", 32'(bus.alu_op), 2);
        step(OpR, 0, 1);
        check("add_rwb", 32'({bus.state, bus.reg_write, bus.reg_dst}), 32'({4'd8, 2'b11}));

        // lw with three wait cycles in MEMRD
        step(OpLw, 0, 1);
        check("lw_fetch", 32'(bus.state), 1);
        step(OpLw, 0, 1);
        step(OpLw, 0, 0);
        check("lw_memadr", 32'(bus.state), 3);
        for (int i = 0; i < 4; i++) begin
            step(OpLw, 0, (i == 3));
            check("lw_memrd", 32'({bus.state, bus.mem_read, bus.i_or_d}), 32'({4'd4, 2'b11}));
        end
        step(OpLw, 0, 1);
        check("lw_memwb", 32'({bus.state, bus.mem_to_reg}), 32'({4'd5, 1'b1}));

        // beq with zero=1
        step(OpBeq, 1, 1);
        step(OpBeq, 1, 1);
        step(OpBeq, 1, 0);
        check("beq_branch",
              32'({bus.state, bus.pc_write_cond, bus.pc_source, bus.alu_op}),
              32'({4'd9, 1'b1, 2'b01, 2'b01}));

        // illegal opcode
        step(OpBad, 0, 1);
        check("ill_fetch", 32'(bus.state), 1);
        step(OpBad, 0, 1);
        step(OpBad, 0, 1);
        check("ill_pulse",
              32'({bus.state, bus.illegal_op, bus.reg_write, bus.mem_write}),
              32'({4'd13, 1'b1, 1'b0, 1'b0}));

        // hung memory in FETCH: four waiting cycles then FAULT, sticky
        for (int i = 0; i < 4; i++) begin
            step(OpJ, 0, 0);
            check("wd_fetch_wait", 32'(bus.state), 1);
        end
        step(OpJ, 0, 1);
        check("wd_fault", 32'({bus.state, bus.mem_fault}), 32'({4'd14, 1'b1}));
        step(OpJ, 0, 1);
        check("wd_fault_sticky", 32'({bus.state, bus.mem_fault}), 32'({4'd14, 1'b1}));
        do_reset();

        // reset in the middle of a stalled sw
        step(OpSw, 0, 1);
        step(OpSw, 0, 1);
        step(OpSw, 0, 0);
        step(OpSw, 0, 0);
        check("sw_memwr", 32'({bus.state, bus.mem_write}), 32'({4'd6, 1'b1}));
        step(OpSw, 0, 0);
        do_reset();
        step(OpJ, 0, 1);
        check("post_rst_fetch", 32'(bus.state), 1);
        step(OpJ, 0, 1);
        step(OpJ, 0, 1);
        check("jump", 32'({bus.state, bus.pc_write, bus.pc_source}), 32'({4'd10, 1'b1, 2'b10}));
        step(OpAddi, 0, 1);
        step(OpAddi, 0, 1);
        step(OpAddi, 0, 1);
        check("addi_ex", 32'(bus.state), 11);
        step(OpAddi, 0, 1);
        check("addi_wb", 32'({bus.state, bus.reg_write, bus.reg_dst}), 32'({4'd12, 2'b10}));

        // random traffic
        rand_op = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ((m_state == 14) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 399) == 0)) begin
                do_reset();
            end else begin
                step(OpR, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
